// File: rtl/systolic_sequencer.sv
// Job sequencer for a ROWS x COLS systolic MAC array: loads weights, streams skewed activations, drains, signals done.
// Optional busy-cycle counter on perf_cycles when SYSTOLIC_SEQ_PERF_EN is defined.
module systolic_sequencer #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vectors,
  output logic                     busy,
  output logic                     done,
  output logic                     w_rd_en,
  output logic [$clog2(ROWS)-1:0]  w_rd_addr,
  input  logic [COLS*DATA_W-1:0]   w_data,
  output logic                     act_rd_en,
  output logic [CNT_W-1:0]         act_rd_addr,
  input  logic [ROWS*DATA_W-1:0]   act_data,
  output logic [ROWS-1:0]          pe_load_weights,
  output logic [COLS*DATA_W-1:0]   pe_weights,
  output logic [ROWS-1:0]          pe_valid,
  output logic [ROWS*DATA_W-1:0]   pe_data,
  output logic [2:0]               state_dbg
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int AW   = $clog2(ROWS);
  localparam int RW   = $clog2(ROWS + 1);
  localparam int DLEN = ROWS + COLS + 1;
  localparam int DW   = $clog2(DLEN);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] k_q;
  logic [RW-1:0]    row_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [DW-1:0]    drain_cnt;
  logic [ROWS-1:0]  ld_q;
  logic             rd_vld;
  logic             accept;

  assign accept    = (state == S_IDLE) && start;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD_W;
      S_LOAD_W: if (row_cnt == ROW_LAST) state_nxt = (k_q != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (vec_cnt == k_q - 1'b1) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    act_rd_en   = 1'b0;
    act_rd_addr = '0;
    case (state)
      S_LOAD_W: begin
        busy = 1'b1;
        if (row_cnt < ROW_LAST) begin
          w_rd_en   = 1'b1;
          w_rd_addr = row_cnt[AW-1:0];
        end
      end
      S_STREAM: begin
        busy        = 1'b1;
        act_rd_en   = 1'b1;
        act_rd_addr = vec_cnt;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // vec_cnt stops at K-1 so a full 2^CNT_W-1 job never wraps the address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q       <= '0;
      row_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      k_q       <= num_vectors;
      row_cnt   <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_LOAD_W: if (row_cnt != ROW_LAST) row_cnt <= row_cnt + 1'b1;
        S_STREAM: if (vec_cnt != k_q - 1'b1) vec_cnt <= vec_cnt + 1'b1;
        S_DRAIN:  if (drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q   <= '0;
      rd_vld <= 1'b0;
    end else begin
      ld_q   <= w_rd_en ? (ROWS'(1) << w_rd_addr) : '0;
      rd_vld <= act_rd_en;
    end
  end

  assign pe_load_weights = ld_q;
  assign pe_weights      = w_data;

  // Lane r is r+1 registers deep, giving the diagonal skew the array expects
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] d_q [0:r];
    logic [r:0]        v_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int j = 0; j <= r; j++) d_q[j] <= '0;
      end else begin
        v_q[0] <= rd_vld;
        d_q[0] <= act_data[r*DATA_W +: DATA_W];
        for (int j = 1; j <= r; j++) begin
          v_q[j] <= v_q[j-1];
          d_q[j] <= d_q[j-1];
        end
      end
    end

    assign pe_valid[r]                  = v_q[r];
    assign pe_data[r*DATA_W +: DATA_W]  = d_q[r];
  end

`ifdef SYSTOLIC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           perf_cycles <= '0;
    else if (accept)                    perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomized scoreboard bench for systolic_sequencer; expectations come from the job timing rules.
// Build with SYSTOLIC_SEQ_PERF_EN defined to also check perf_cycles.
module tb_systolic_sequencer;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int DLEN = R + C + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CW-1:0]     num_vectors;
  logic              busy;
  logic              done;
  logic              w_rd_en;
  logic [1:0]        w_rd_addr;
  logic [C*DW-1:0]   w_data;
  logic              act_rd_en;
  logic [CW-1:0]     act_rd_addr;
  logic [R*DW-1:0]   act_data;
  logic [R-1:0]      pe_load_weights;
  logic [C*DW-1:0]   pe_weights;
  logic [R-1:0]      pe_valid;
  logic [R*DW-1:0]   pe_data;
  logic [2:0]        state_dbg;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  systolic_sequencer #(.ROWS(R), .COLS(C), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_data(w_data), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .act_data(act_data), .pe_load_weights(pe_load_weights),
    .pe_weights(pe_weights), .pe_valid(pe_valid), .pe_data(pe_data),
    .state_dbg(state_dbg)
`ifdef SYSTOLIC_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  typedef struct {
    int          cyc;
    int          lane;
    logic [63:0] val;
  } ev_t;

  ev_t w_q[$];
  ev_t ld_q[$];
  ev_t act_q[$];
  ev_t pe_q[$];
  ev_t done_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int busy_lo  = 1;
  int busy_hi  = 0;

  logic [C*DW-1:0] w_mem   [R];
  logic [R*DW-1:0] act_mem [256];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency memories
  always @(posedge clk) begin
    if (w_rd_en)   w_data   <= w_mem[w_rd_addr];
    if (act_rd_en) act_data <= act_mem[act_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  task automatic stream_chk(input string name, input bit exp_p, input logic [63:0] exp_v,
                            input bit act_p, input logic [63:0] act_v);
    chk({name, "_present"}, 64'(act_p), 64'(exp_p));
    if (exp_p && act_p) chk({name, "_value"}, act_v, exp_v);
  endtask

  function automatic int job_len(input int k);
    return R + 1 + k + ((k > 0) ? DLEN : 0) + 1;
  endfunction

  // reference model: expected event schedule of one job started in cycle s
  task automatic push_job(input int s, input int k);
    int ss;
    int v;
    logic [R-1:0] oh;
    for (int i = 0; i < R; i++) begin
      w_mem[i] = $urandom;
      oh = 4'b0001 << i;
      w_q.push_back('{s + 1 + i, 0, 64'(i)});
      ld_q.push_back('{s + 2 + i, 0, 64'({oh, w_mem[i]})});
    end
    ss = s + R + 2;
    for (int i = 0; i < k; i++) begin
      act_mem[i] = $urandom;
      act_q.push_back('{ss + i, 0, 64'(i)});
    end
    for (int c = ss + 2; c <= ss + k + R; c++)
      for (int r = 0; r < R; r++) begin
        v = c - ss - 2 - r;
        if (v >= 0 && v < k) pe_q.push_back('{c, r, 64'(act_mem[v][r*DW +: DW])});
      end
    done_q.push_back('{s + job_len(k), 0, 64'(0)});
    busy_lo = s + 1;
    busy_hi = s + job_len(k);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    ev_t e;
    bit  p;
    if (rst) begin
      chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));

      p = 0; e = '{0, 0, 64'(0)};
      if (w_q.size() > 0 && w_q[0].cyc == cyc) begin e = w_q.pop_front(); p = 1; end
      stream_chk("w_rd", p, e.val, w_rd_en, 64'(w_rd_addr));

      p = 0; e = '{0, 0, 64'(0)};
      if (ld_q.size() > 0 && ld_q[0].cyc == cyc) begin e = ld_q.pop_front(); p = 1; end
      stream_chk("load_w", p, e.val, |pe_load_weights, 64'({pe_load_weights, pe_weights}));

      p = 0; e = '{0, 0, 64'(0)};
      if (act_q.size() > 0 && act_q[0].cyc == cyc) begin e = act_q.pop_front(); p = 1; end
      stream_chk("act_rd", p, e.val, act_rd_en, 64'(act_rd_addr));

      for (int r = 0; r < R; r++) begin
        p = 0; e = '{0, 0, 64'(0)};
        if (pe_q.size() > 0 && pe_q[0].cyc == cyc && pe_q[0].lane == r) begin
          e = pe_q.pop_front(); p = 1;
        end
        stream_chk($sformatf("pe_lane%0d", r), p, e.val, pe_valid[r], 64'(pe_data[r*DW +: DW]));
      end

      p = 0; e = '{0, 0, 64'(0)};
      if (done_q.size() > 0 && done_q[0].cyc == cyc) begin e = done_q.pop_front(); p = 1; end
      stream_chk("done", p, e.val, done, 64'(0));
    end
  end

  // driver tasks
  task automatic run_job(input int k, input int ign);
    int s;
    int len;
    @(posedge clk); #1;
    s = cyc;
    push_job(s, k);
    start       = 1'b1;
    num_vectors = CW'(k);
    len = job_len(k);
    for (int t = 1; t <= len; t++) begin
      @(posedge clk); #1;
      start       = (t == ign);
      num_vectors = (t == ign) ? 8'd9 : CW'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(len));
`endif
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic reset_mid_job(input int at);
    int s;
    @(posedge clk); #1;
    s = cyc;
    push_job(s, 3);
    start       = 1'b1;
    num_vectors = 8'd3;
    for (int t = 1; t <= at; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b0;
    w_q.delete(); ld_q.delete(); act_q.delete(); pe_q.delete(); done_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pe_valid", 64'(pe_valid), 64'(0));
    chk("rst_act_rd_en", 64'(act_rd_en), 64'(0));
    chk("rst_pe_data", 64'(pe_data), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_w_rd_en"}, 64'(w_rd_en), 64'(0));
    chk({tag, "_w_rd_addr"}, 64'(w_rd_addr), 64'(0));
    chk({tag, "_act_rd_en"}, 64'(act_rd_en), 64'(0));
    chk({tag, "_act_rd_addr"}, 64'(act_rd_addr), 64'(0));
    chk({tag, "_pe_load_weights"}, 64'(pe_load_weights), 64'(0));
    chk({tag, "_pe_valid"}, 64'(pe_valid), 64'(0));
    chk({tag, "_pe_data"}, 64'(pe_data), 64'(0));
`ifdef SYSTOLIC_SEQ_PERF_EN
    chk({tag, "_perf_cycles"}, 64'(perf_cycles), 64'(0));
`endif
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    num_vectors = '0;
    w_data      = '0;
    act_data    = '0;
    @(negedge clk);
    chk_all_zero("in_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");
    repeat (20) @(posedge clk);

    run_job(3, 0);
    run_job(3, 7);
    run_job(0, 0);
    run_job(0, 3);
    run_job(255, 100);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = $urandom_range(1, 20);
      run_job(k, $urandom_range(0, job_len(k)));
    end

    reset_mid_job(7);
    repeat (2) @(posedge clk);
    run_job(1, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("w_q_drained", 64'(w_q.size()), 64'(0));
    chk("ld_q_drained", 64'(ld_q.size()), 64'(0));
    chk("act_q_drained", 64'(act_q.size()), 64'(0));
    chk("pe_q_drained", 64'(pe_q.size()), 64'(0));
    chk("done_q_drained", 64'(done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
